seq_magnitude_comparator: RTL and testbench

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/magcmp_pkg.sv | 36 +++
 rtl/magcmp_slice.sv | 18 +
 rtl/seq_magnitude_comparator.sv | 129 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/magcmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: FSM states,
// result codes {gt,lt,eq} and the cascade-input resolution used when all
// slices compare equal.
package magcmp_pkg;

  typedef logic [2:0] res_t;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COMPARE = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  localparam res_t RES_GT   = 3'b100;
  localparam res_t RES_LT   = 3'b010;
  localparam res_t RES_EQ   = 3'b001;
  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_BOTH = 3'b110;

  // 74LS85-style cascade: ieq dominates, otherwise igt/ilt pass through,
  // both-high gives neither and both-low gives both.
  function automatic res_t cascade_resolve(input logic [2:0] casc);
    res_t r;
    r = RES_NONE;
    if (casc[0]) begin
      r = RES_EQ;
    end else begin
      case (casc[2:1])
        2'b10:   r = RES_GT;
        2'b01:   r = RES_LT;
        2'b11:   r = RES_NONE;
        default: r = RES_BOTH;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/magcmp_slice.sv
// Purpose: unsigned compare of one SLICE-bit slice into gt/lt/eq.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module magcmp_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Purpose: multi-cycle unsigned A/B compare, MSB slice first, with 74LS85 cascade inputs.
// Latency: start-to-done NSLICE+1 cycles; k+1 when MAGCMP_EARLY_EXIT_EN is defined.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module seq_magnitude_comparator
  import magcmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             igt,
  input  logic             ilt,
  input  logic             ieq,
  output logic             busy,
  output logic             done,
  output logic             ogt,
  output logic             olt,
  output logic             oeq
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

`ifdef MAGCMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       casc_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q;
  res_t             pend_q;
  res_t             res_q;
  logic             done_q;

  logic             sl_gt;
  logic             sl_lt;
  logic             sl_eq;
  logic             decided_nx;
  res_t             pend_nx;
  logic             go_done;
  res_t             final_res;

  // Operands are shifted left each step, so the slice under test is always the top one.
  magcmp_slice #(.WIDTH(SLICE)) u_slice (
    .a  (a_q[WIDTH-1 -: SLICE]),
    .b  (b_q[WIDTH-1 -: SLICE]),
    .gt (sl_gt),
    .lt (sl_lt),
    .eq (sl_eq)
  );

  // First unequal slice wins; later slices never override a decided result.
  always_comb begin
    decided_nx = decided_q | ~sl_eq;
    pend_nx    = pend_q;
    if (!decided_q && sl_gt) begin
      pend_nx = RES_GT;
    end else if (!decided_q && sl_lt) begin
      pend_nx = RES_LT;
    end
    go_done   = (idx_q == '0) || (EARLY_EXIT && decided_nx);
    final_res = decided_nx ? pend_nx : cascade_resolve(casc_q);
  end

  // FSM plus datapath; the result and done are registered on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      casc_q    <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      pend_q    <= RES_NONE;
      res_q     <= RES_NONE;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            casc_q    <= {igt, ilt, ieq};
            idx_q     <= IDX_W'(NSLICE - 1);
            decided_q <= 1'b0;
            pend_q    <= RES_NONE;
            state_q   <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (go_done) begin
            res_q   <= final_res;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q     <= idx_q - 1'b1;
            a_q       <= a_q << SLICE;
            b_q       <= b_q << SLICE;
            decided_q <= decided_nx;
            pend_q    <= pend_nx;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign {ogt, olt, oeq} = res_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, SLICE=4).
// Expected latencies follow the build: MAGCMP_EARLY_EXIT_EN defined or not.
module tb_seq_magnitude_comparator;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int NS = W / SL;

`ifdef MAGCMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          igt;
  logic          ilt;
  logic          ieq;
  logic          busy;
  logic          done;
  logic          ogt;
  logic          olt;
  logic          oeq;

  int checks = 0;
  int errors = 0;

  seq_magnitude_comparator #(.WIDTH(W), .SLICE(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .igt   (igt),
    .ilt   (ilt),
    .ieq   (ieq),
    .busy  (busy),
    .done  (done),
    .ogt   (ogt),
    .olt   (olt),
    .oeq   (oeq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   casc;
    logic [2:0]   exp_res;
    int           exp_lat;
  } vec_t;

  vec_t vecs[12];

  // Latency when k slices have to be looked at before the answer is known.
  function automatic int lat_of(input int k);
    return EE ? k + 1 : NS + 1;
  endfunction

  // Cascade behaviour written straight from the truth table.
  function automatic logic [2:0] casc_model(input logic [2:0] c);
    case (c)
      3'b100:  return 3'b100;
      3'b010:  return 3'b010;
      3'b110:  return 3'b000;
      3'b000:  return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  // Whole-word reference: magnitude from plain comparison, slices needed from the top differing bit.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mc,
                       output logic [2:0] r, output int l);
    logic [W-1:0] x;
    int msb;
    x   = ma ^ mb;
    msb = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (msb < 0 && x[i]) msb = i;
    end
    if (ma > mb)      r = 3'b100;
    else if (ma < mb) r = 3'b010;
    else              r = casc_model(mc);
    l = lat_of((msb < 0) ? NS : NS - (msb / SL));
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [2:0] tc,
                        output logic [2:0] r, output int l);
    a = ta;
    b = tb2;
    {igt, ilt, ieq} = tc;
    start = 1'b1;
    l = 0;
    r = 3'b000;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        l = n;
        r = {ogt, olt, oeq};
        break;
      end
    end
  endtask

  task automatic do_check(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic [2:0] tc, input logic [2:0] exp_res, input int exp_lat);
    logic [2:0] r;
    int l;
    run_op(ta, tb2, tc, r, l);
    chk({nm, " latency"}, l, exp_lat);
    chk({nm, " result"}, int'(r), int'(exp_res));
    @(negedge clk);
    chk({nm, " hold"}, int'({busy, done, ogt, olt, oeq}), int'({2'b00, exp_res}));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc, mr, r1, r2;
    int           ml, d1, d2, cnt;

    vecs[0]  = '{16'h8000, 16'h7FFF, 3'b001, 3'b100, lat_of(1)};
    vecs[1]  = '{16'h1234, 16'h1234, 3'b001, 3'b001, lat_of(4)};
    vecs[2]  = '{16'h1234, 16'h1234, 3'b100, 3'b100, lat_of(4)};
    vecs[3]  = '{16'h1234, 16'h1234, 3'b010, 3'b010, lat_of(4)};
    vecs[4]  = '{16'h1234, 16'h1234, 3'b110, 3'b000, lat_of(4)};
    vecs[5]  = '{16'h1234, 16'h1234, 3'b000, 3'b110, lat_of(4)};
    vecs[6]  = '{16'h1234, 16'h1234, 3'b111, 3'b001, lat_of(4)};
    vecs[7]  = '{16'h1234, 16'h1243, 3'b000, 3'b010, lat_of(3)};
    vecs[8]  = '{16'h0000, 16'h0001, 3'b100, 3'b010, lat_of(4)};
    vecs[9]  = '{16'hFFFF, 16'h0000, 3'b010, 3'b100, lat_of(1)};
    vecs[10] = '{16'h0A00, 16'h0900, 3'b001, 3'b100, lat_of(2)};
    vecs[11] = '{16'h0000, 16'h0000, 3'b011, 3'b001, lat_of(4)};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    {igt, ilt, ieq} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", int'({busy, done, ogt, olt, oeq}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].casc,
               vecs[i].exp_res, vecs[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ (16'h0001 << $urandom_range(15, 0));
        default: rb = W'($urandom);
      endcase
      rc = 3'($urandom_range(7, 0));
      model(ra, rb, rc, mr, ml);
      do_check($sformatf("rand%0d", i), ra, rb, rc, mr, ml);
    end

    // Operand change after capture and a start pulse while busy must both be ignored.
    a = 16'h00F0;
    b = 16'h00F1;
    {igt, ilt, ieq} = 3'b001;
    start = 1'b1;
    d1 = 0;
    r1 = 3'b000;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin
        d1 = n;
        r1 = {ogt, olt, oeq};
        break;
      end
      start = (n == 2);
      if (n == 1) a = 16'hFFFF;
    end
    start = 1'b0;
    chk("capture latency", d1, lat_of(4));
    chk("capture result", int'(r1), 3'b010);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("busy start ignored", cnt, 0);
    chk("idle after ignore", int'({busy, ogt, olt, oeq}), int'({1'b0, 3'b010}));

    // Reset in the third COMPARE cycle aborts without a done pulse.
    do_check("pre-reset", 16'hFFFF, 16'h0000, 3'b001, 3'b100, lat_of(1));
    a = 16'h0001;
    b = 16'h0002;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy before abort", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", int'({busy, done, ogt, olt, oeq}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no done after abort", cnt, 0);
    do_check("post-reset", 16'h0001, 16'h0002, 3'b001, 3'b010, lat_of(4));

    // Back-to-back: second start in the IDLE cycle right after DONE.
    run_op(16'h0001, 16'h0002, 3'b001, r1, d1);
    chk("b2b first latency", d1, lat_of(4));
    chk("b2b first result", int'(r1), 3'b010);
    @(negedge clk);
    chk("b2b idle gap", int'(busy), 0);
    run_op(16'h0002, 16'h0001, 3'b001, r2, d2);
    chk("b2b second result", int'(r2), 3'b100);
    chk("b2b done spacing", d2 + 1, lat_of(4) + 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
